// File: rtl/horizontal_tf_rom_writer.sv
// horizontal_tf_rom_writer
//   Packs the eight processed twiddle lanes from the horizontal twiddle
//   generator into SRAM lines and writes them into the eight radix-16
//   twiddle banks. Bank0 is 64 bits wide: one TF word per line, zero-extended
//   on bank_wdata. Banks 1..7 are 128 bits wide: two TF words per line.
//   done rises once every bank holds DEPTH lines.
//
// Ports
//   clk, rst_n     clock (rising edge); reset is asynchronous and active-high
//   start          1-cycle pulse: clear counters/holding state, enter FILL
//   rom0_data/_w   bank0 TF word and write strobe
//   romk_data/_w   banks1..7 TF words (P_WIDTH each) and 2-bit half strobes
//   bank_cen_n     per-bank SRAM chip enable, active-low
//   bank_wen_n     per-bank SRAM write enable, active-low
//   bank_addr      per-bank line address, AW bits each
//   bank_wdata     per-bank line data, SD_WIDTH bits each
//   busy / done    FSM in FILL / FSM in DONE
//   ovf            sticky: strobe outside FILL or into a full bank
//   checksum       XOR of every committed line
//
// Configuration
//   TF_WR_CHECKSUM_EN  when defined, checksum accumulates the XOR of all
//                      committed lines; otherwise checksum is tied to zero.
module horizontal_tf_rom_writer #(
  parameter int P_WIDTH  = 64,
  parameter int SD_WIDTH = 128,
  parameter int AW       = 10,
  parameter int DEPTH    = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [P_WIDTH-1:0]    rom0_data,
  input  logic                  rom0_w,
  input  logic [7*P_WIDTH-1:0]  romk_data,
  input  logic [13:0]           romk_w,
  output logic [7:0]            bank_cen_n,
  output logic [7:0]            bank_wen_n,
  output logic [8*AW-1:0]       bank_addr,
  output logic [8*SD_WIDTH-1:0] bank_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [SD_WIDTH-1:0]   checksum
);

  // Counters need one extra bit: they must be able to hold DEPTH == 2**AW.
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

  state_t state, state_nxt;

  logic [CW-1:0]       cnt [8];
  logic [P_WIDTH-1:0]  lo [7];
  logic [P_WIDTH-1:0]  hi [7];
  logic [6:0]          lo_v, hi_v;

  logic [P_WIDTH-1:0]  lo_nxt [7];
  logic [P_WIDTH-1:0]  hi_nxt [7];
  logic [6:0]          lo_v_nxt, hi_v_nxt;
  logic [1:0]          kw [7];
  logic [P_WIDTH-1:0]  kd [7];
  logic [SD_WIDTH-1:0] line [8];
  logic [7:0]          commit;
  logic [7:0]          full;
  logic [7:0]          strobe;
  logic                in_fill;
  logic                ovf_set;

  // FSM state register
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // FSM next state: start always (re)enters FILL, even from FILL itself
  always_comb begin
    state_nxt = state;
    if (start)
      state_nxt = S_FILL;
    else if (state == S_FILL && (&full))
      state_nxt = S_DONE;
  end

  // FSM outputs
  always_comb begin
    busy = (state == S_FILL);
    done = (state == S_DONE);
  end

  // Stage p0: strobe decode, half-line assembly, commit decision
  always_comb begin
    in_fill = (state == S_FILL) && !start;

    for (int b = 0; b < 8; b++)
      full[b] = (cnt[b] == CW'(DEPTH));

    strobe    = '0;
    strobe[0] = rom0_w;
    line[0]   = SD_WIDTH'(rom0_data);
    commit    = '0;
    commit[0] = in_fill && rom0_w && !full[0];

    lo_v_nxt = lo_v;
    hi_v_nxt = hi_v;
    for (int k = 0; k < 7; k++) begin
      kw[k]        = romk_w[2*k +: 2];
      kd[k]        = romk_data[k*P_WIDTH +: P_WIDTH];
      lo_nxt[k]    = lo[k];
      hi_nxt[k]    = hi[k];
      strobe[k+1]  = |kw[k];
      if (in_fill && (|kw[k]) && !full[k+1]) begin
        if (kw[k][0]) begin
          lo_nxt[k]   = kd[k];
          lo_v_nxt[k] = 1'b1;
        end
        if (kw[k][1]) begin
          hi_nxt[k]   = kd[k];
          hi_v_nxt[k] = 1'b1;
        end
        // Commit in the same cycle the second half arrives.
        if (lo_v_nxt[k] && hi_v_nxt[k]) begin
          commit[k+1] = 1'b1;
          lo_v_nxt[k] = 1'b0;
          hi_v_nxt[k] = 1'b0;
        end
      end
      line[k+1] = {hi_nxt[k], lo_nxt[k]};
    end

    // Strobes in the start cycle are dropped silently, never flagged.
    ovf_set = !start && (((state != S_FILL) && (|strobe)) ||
                         ((state == S_FILL) && (|(strobe & full))));
  end

  // Stage p1: registered holding state, counters and SRAM port
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int b = 0; b < 8; b++) cnt[b] <= '0;
      for (int k = 0; k < 7; k++) begin
        lo[k] <= '0;
        hi[k] <= '0;
      end
      lo_v       <= '0;
      hi_v       <= '0;
      ovf        <= 1'b0;
      bank_cen_n <= 8'hFF;
      bank_wen_n <= 8'hFF;
      bank_addr  <= '0;
      bank_wdata <= '0;
    end else begin
      if (start) begin
        for (int b = 0; b < 8; b++) cnt[b] <= '0;
        for (int k = 0; k < 7; k++) begin
          lo[k] <= '0;
          hi[k] <= '0;
        end
        lo_v <= '0;
        hi_v <= '0;
        ovf  <= 1'b0;
      end else begin
        for (int k = 0; k < 7; k++) begin
          lo[k] <= lo_nxt[k];
          hi[k] <= hi_nxt[k];
        end
        lo_v <= lo_v_nxt;
        hi_v <= hi_v_nxt;
        // commit is never raised on a full bank, so counters stop at DEPTH.
        for (int b = 0; b < 8; b++)
          if (commit[b]) cnt[b] <= cnt[b] + CW'(1);
        if (ovf_set) ovf <= 1'b1;
      end

      bank_cen_n <= ~commit;
      bank_wen_n <= ~commit;
      for (int b = 0; b < 8; b++) begin
        if (commit[b]) begin
          bank_addr[b*AW +: AW]             <= cnt[b][AW-1:0];
          bank_wdata[b*SD_WIDTH +: SD_WIDTH] <= line[b];
        end
      end
    end
  end

`ifdef TF_WR_CHECKSUM_EN
  logic [SD_WIDTH-1:0] cs_delta;

  always_comb begin
    cs_delta = '0;
    for (int b = 0; b < 8; b++)
      if (commit[b]) cs_delta = cs_delta ^ line[b];
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)      checksum <= '0;
    else if (start) checksum <= '0;
    else            checksum <= checksum ^ cs_delta;
  end
`else
  assign checksum = '0;
`endif

endmodule
